// File: rtl/parallel_port_edge.sv
// Memory-mapped parallel port with per-bit edge capture, masked level interrupt and an
// optional per-bit debounce filter enabled by defining PARALLEL_PORT_DEBOUNCE_EN.
module parallel_port_edge #(
   parameter int unsigned DW              = 32,
   parameter int unsigned EDGE_MODE       = 0,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    address,
   input  logic          chipselect,
   input  logic          read,
   input  logic          write,
   input  logic [31:0]   writedata,
   output logic [31:0]   readdata,
   output logic          irq,
   input  logic [DW-1:0] gpio_in,
   output logic [DW-1:0] gpio_out,
   output logic [DW-1:0] gpio_oe
);

   logic [DW-1:0] sync1_q, sync1_d;
   logic [DW-1:0] sync2_q, sync2_d;
   logic [DW-1:0] sync_in;
   logic [DW-1:0] filt_in;
   logic [DW-1:0] prev_q, prev_d;
   logic [DW-1:0] data_q, data_d;
   logic [DW-1:0] dir_q, dir_d;
   logic [DW-1:0] mask_q, mask_d;
   logic [DW-1:0] capture_q, capture_d;
   logic [31:0]   readdata_q, readdata_d;
   logic          irq_q, irq_d;
   logic [DW-1:0] edge_det;
   logic [DW-1:0] wr_val;
   logic [DW-1:0] rd_val;
   logic          wr_en;
   logic          rd_en;
   logic          unused_wd;

   assign wr_en     = chipselect & write;
   assign rd_en     = chipselect & read;
   assign wr_val    = writedata[DW-1:0];
   assign unused_wd = ^writedata;
   assign sync_in   = sync2_q;

`ifdef PARALLEL_PORT_DEBOUNCE_EN
   localparam logic [15:0] CntMax = 16'(DEBOUNCE_CYCLES - 1);

   logic [DW-1:0] deb_q, deb_d;
   logic [15:0]   cnt_q [DW];
   logic [15:0]   cnt_d [DW];

   // Counter runs only while the synchronized input disagrees with the debounced value.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < DW; i++) begin
         cnt_d[i] = '0;
         if (sync_in[i] != deb_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               deb_d[i] = sync_in[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         deb_q <= '0;
         for (int i = 0; i < DW; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         deb_q <= deb_d;
         for (int i = 0; i < DW; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign filt_in = deb_q;
`else
   logic unused_cfg;
   assign unused_cfg = (DEBOUNCE_CYCLES == 0);
   assign filt_in    = sync_in;
`endif

   always_comb begin
      if (EDGE_MODE == 0) begin
         edge_det = filt_in & ~prev_q;
      end else if (EDGE_MODE == 1) begin
         edge_det = ~filt_in & prev_q;
      end else begin
         edge_det = filt_in ^ prev_q;
      end
   end

   always_comb begin
      rd_val = '0;
      case (address)
         2'd0:    rd_val = (dir_q & data_q) | (~dir_q & filt_in);
         2'd1:    rd_val = dir_q;
         2'd2:    rd_val = mask_q;
         default: rd_val = capture_q;
      endcase
   end

   always_comb begin
      sync1_d    = gpio_in;
      sync2_d    = sync1_q;
      prev_d     = filt_in;
      data_d     = data_q;
      dir_d      = dir_q;
      mask_d     = mask_q;
      capture_d  = capture_q;
      readdata_d = readdata_q;
      irq_d      = |(capture_q & mask_q);
      if (wr_en) begin
         case (address)
            2'd0:    data_d    = wr_val;
            2'd1:    dir_d     = wr_val;
            2'd2:    mask_d    = wr_val;
            default: capture_d = capture_q & ~wr_val;
         endcase
      end
      // Set wins over a simultaneous write-one-to-clear.
      capture_d = capture_d | edge_det;
      if (rd_en) begin
         readdata_d         = '0;
         readdata_d[DW-1:0] = rd_val;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         prev_q     <= '0;
         data_q     <= '0;
         dir_q      <= '0;
         mask_q     <= '0;
         capture_q  <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         prev_q     <= prev_d;
         data_q     <= data_d;
         dir_q      <= dir_d;
         mask_q     <= mask_d;
         capture_q  <= capture_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;
   assign gpio_out = data_q;
   assign gpio_oe  = dir_q;

endmodule

// File: tb/tb_parallel_port_edge.sv
// Directed bench: a 32-bit rising-edge port and an 8-bit any-edge port share one bus.
module tb_parallel_port_edge;

   logic        clk;
   logic        reset;
   logic [1:0]  addr;
   logic        cs;
   logic        rd_s;
   logic        wr_s;
   logic [31:0] wdata;
   logic [31:0] gpio_in;

   logic [31:0] r_readdata;
   logic        r_irq;
   logic [31:0] r_out;
   logic [31:0] r_oe;
   logic [31:0] a_readdata;
   logic        a_irq;
   logic [7:0]  a_out;
   logic [7:0]  a_oe;

   int n_checks;
   int n_fail;

`ifdef PARALLEL_PORT_DEBOUNCE_EN
   localparam int EdgeLat = 18;
`else
   localparam int EdgeLat = 2;
`endif

   parallel_port_edge #(
      .DW(32),
      .EDGE_MODE(0),
      .DEBOUNCE_CYCLES(16)
   ) dut_r (
      .clk(clk),
      .reset(reset),
      .address(addr),
      .chipselect(cs),
      .read(rd_s),
      .write(wr_s),
      .writedata(wdata),
      .readdata(r_readdata),
      .irq(r_irq),
      .gpio_in(gpio_in),
      .gpio_out(r_out),
      .gpio_oe(r_oe)
   );

   parallel_port_edge #(
      .DW(8),
      .EDGE_MODE(2),
      .DEBOUNCE_CYCLES(16)
   ) dut_a (
      .clk(clk),
      .reset(reset),
      .address(addr),
      .chipselect(cs),
      .read(rd_s),
      .write(wr_s),
      .writedata(wdata),
      .readdata(a_readdata),
      .irq(a_irq),
      .gpio_in(gpio_in[7:0]),
      .gpio_out(a_out),
      .gpio_oe(a_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      cs    = 1'b1;
      wr_s  = 1'b1;
      addr  = a;
      wdata = d;
      tick(1);
      cs    = 1'b0;
      wr_s  = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a);
      cs   = 1'b1;
      rd_s = 1'b1;
      addr = a;
      tick(1);
      cs   = 1'b0;
      rd_s = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      addr     = '0;
      cs       = 1'b0;
      rd_s     = 1'b0;
      wr_s     = 1'b0;
      wdata    = '0;
      gpio_in  = '0;
      tick(3);
      chk("rst_r_readdata", r_readdata, 32'h0);
      chk("rst_r_irq", {31'b0, r_irq}, 32'h0);
      chk("rst_r_out", r_out, 32'h0);
      chk("rst_r_oe", r_oe, 32'h0);
      chk("rst_a_irq", {31'b0, a_irq}, 32'h0);
      reset = 1'b0;
      tick(1);

      // Register write / read-back
      bus_wr(2'd0, 32'h0000_00A5);
      bus_wr(2'd1, 32'h0000_00FF);
      chk("wr_r_out", r_out, 32'h0000_00A5);
      chk("wr_r_oe", r_oe, 32'h0000_00FF);
      chk("wr_a_out", {24'b0, a_out}, 32'h0000_00A5);
      chk("wr_a_oe", {24'b0, a_oe}, 32'h0000_00FF);
      bus_rd(2'd0);
      chk("rd0_r", r_readdata, 32'h0000_00A5);
      chk("rd0_a", a_readdata, 32'h0000_00A5);
      tick(2);
      chk("rd_hold_r", r_readdata, 32'h0000_00A5);

      // Read and write together: read returns the old direction
      cs = 1'b1; rd_s = 1'b1; wr_s = 1'b1; addr = 2'd1; wdata = 32'h0000_000F;
      tick(1);
      cs = 1'b0; rd_s = 1'b0; wr_s = 1'b0;
      chk("rw_old_dir", r_readdata, 32'h0000_00FF);
      chk("rw_new_oe", r_oe, 32'h0000_000F);

      // Write without chipselect is ignored
      wr_s = 1'b1; addr = 2'd0; wdata = 32'h0000_00FF;
      tick(1);
      wr_s = 1'b0;
      chk("nocs_out", r_out, 32'h0000_00A5);

      bus_wr(2'd2, 32'hFFFF_FF01);
      bus_rd(2'd2);
      chk("mask_r", r_readdata, 32'hFFFF_FF01);
      chk("mask_a_narrow", a_readdata, 32'h0000_0001);
      bus_wr(2'd2, 32'h0000_0001);

      // Mixed-direction data read and capture W1C behaviour
      gpio_in = 32'h0000_0030;
      tick(25);
      bus_rd(2'd0);
      chk("mix_r", r_readdata, 32'h0000_0035);
      chk("mix_a", a_readdata, 32'h0000_0035);
      bus_wr(2'd3, 32'h0);
      bus_rd(2'd3);
      chk("w1c0_r", r_readdata, 32'h0000_0030);
      chk("irq_masked_r", {31'b0, r_irq}, 32'h0);
      bus_wr(2'd3, 32'h0000_0010);
      gpio_in = 32'h0;
      tick(25);
      bus_rd(2'd3);
      chk("fall_r", r_readdata, 32'h0000_0020);
      chk("fall_a", a_readdata, 32'h0000_0030);
      bus_wr(2'd3, 32'hFFFF_FFFF);
      bus_rd(2'd3);
      chk("clr_r", r_readdata, 32'h0);
      chk("clr_a", a_readdata, 32'h0);

      // Rising capture with irq, then W1C
      gpio_in[0] = 1'b1;
      tick(25);
      bus_rd(2'd3);
      chk("rise_cap_r", r_readdata, 32'h0000_0001);
      chk("rise_irq_r", {31'b0, r_irq}, 32'h1);
      chk("rise_irq_a", {31'b0, a_irq}, 32'h1);
      bus_wr(2'd3, 32'h0000_0001);
      chk("w1c_irq_lag", {31'b0, r_irq}, 32'h1);
      tick(1);
      chk("w1c_irq_r", {31'b0, r_irq}, 32'h0);
      bus_rd(2'd3);
      chk("w1c_cap_r", r_readdata, 32'h0);
      gpio_in[0] = 1'b0;
      tick(25);
      chk("fall0_irq_r", {31'b0, r_irq}, 32'h0);
      chk("fall0_irq_a", {31'b0, a_irq}, 32'h1);
      bus_wr(2'd3, 32'hFFFF_FFFF);
      tick(1);
      chk("fall0_clr_a", {31'b0, a_irq}, 32'h0);

      // W1C in the same cycle an edge on bit 2 is detected
      gpio_in[2] = 1'b1;
      tick(EdgeLat);
      bus_wr(2'd3, 32'h0000_0004);
      bus_rd(2'd3);
      chk("collide_r", r_readdata, 32'h0000_0004);
      chk("collide_a", a_readdata, 32'h0000_0004);
      bus_wr(2'd3, 32'h0000_0004);
      gpio_in[2] = 1'b0;
      tick(25);
      bus_wr(2'd3, 32'hFFFF_FFFF);
      bus_rd(2'd3);
      chk("collide_clr_r", r_readdata, 32'h0);

`ifdef PARALLEL_PORT_DEBOUNCE_EN
      gpio_in[1] = 1'b1;
      tick(10);
      gpio_in[1] = 1'b0;
      tick(25);
      bus_rd(2'd3);
      chk("glitch_r", r_readdata, 32'h0);
      chk("glitch_a", a_readdata, 32'h0);
      gpio_in[1] = 1'b1;
      tick(20);
      gpio_in[1] = 1'b0;
      tick(25);
      bus_rd(2'd3);
      chk("stable_r", r_readdata, 32'h0000_0002);
      chk("stable_a", a_readdata, 32'h0000_0002);
`else
      gpio_in[1] = 1'b1;
      tick(3);
      gpio_in[1] = 1'b0;
      tick(25);
      bus_rd(2'd3);
      chk("pulse_r", r_readdata, 32'h0000_0002);
      chk("pulse_a", a_readdata, 32'h0000_0002);
`endif
      bus_wr(2'd3, 32'hFFFF_FFFF);

      // Any-edge pulse on bit 3
      bus_wr(2'd2, 32'h0000_0008);
      gpio_in[3] = 1'b1;
      tick(20);
      gpio_in[3] = 1'b0;
      tick(30);
      bus_rd(2'd3);
      chk("any_cap_a", a_readdata, 32'h0000_0008);
      chk("any_cap_r", r_readdata, 32'h0000_0008);
      chk("any_irq_a", {31'b0, a_irq}, 32'h1);
      tick(5);
      chk("any_irq_hold_a", {31'b0, a_irq}, 32'h1);

      // Reset with capture and mask populated and edges in flight
      bus_wr(2'd2, 32'h0000_000F);
      gpio_in = 32'h0000_000F;
      tick(25);
      bus_rd(2'd3);
      chk("pre_rst_cap_r", r_readdata, 32'h0000_000F);
      chk("pre_rst_irq_r", {31'b0, r_irq}, 32'h1);
      gpio_in = 32'h0;
      reset   = 1'b1;
      tick(1);
      chk("mid_rst_irq_r", {31'b0, r_irq}, 32'h0);
      chk("mid_rst_irq_a", {31'b0, a_irq}, 32'h0);
      chk("mid_rst_rd_r", r_readdata, 32'h0);
      chk("mid_rst_out_r", r_out, 32'h0);
      chk("mid_rst_oe_r", r_oe, 32'h0);
      reset = 1'b0;
      tick(1);
      chk("post_rst_irq_a", {31'b0, a_irq}, 32'h0);
      tick(25);
      bus_rd(2'd3);
      chk("post_rst_cap_r", r_readdata, 32'h0);
      chk("post_rst_cap_a", a_readdata, 32'h0);
      bus_rd(2'd2);
      chk("post_rst_mask_r", r_readdata, 32'h0);
      bus_rd(2'd1);
      chk("post_rst_dir_r", r_readdata, 32'h0);
      bus_rd(2'd0);
      chk("post_rst_data_r", r_readdata, 32'h0);
      chk("post_rst_irq_end", {31'b0, a_irq | r_irq}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/parallel_port_edge.md
PARALLEL_PORT_EDGE -- requirements
Module: parallel_port_edge

Interface
REQ-001 SHALL have parameter DW, default 32, port width in bits, legal range 1..32.
REQ-002 SHALL have parameter EDGE_MODE, default 0, capture edge select: 0 rising, 1 falling, 2 any.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, stable-cycle count for the debounce filter, legal range 2..65535.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port address  input  2  register select: 0 data, 1 direction, 2 irq mask, 3 edge capture.
REQ-007 SHALL have port chipselect  input  1  qualifies read and write.
REQ-008 SHALL have port read  input  1  read strobe.
REQ-009 SHALL have port write  input  1  write strobe.
REQ-010 SHALL have port writedata  input  32  write data; bits above DW-1 ignored.
REQ-011 SHALL have port readdata  output  32  registered read data; bits above DW-1 read 0.
REQ-012 SHALL have port irq  output  1  level interrupt request.
REQ-013 SHALL have port gpio_in  input  DW  asynchronous pin inputs.
REQ-014 SHALL have port gpio_out  output  DW  output data register value.
REQ-015 SHALL have port gpio_oe  output  DW  per-bit output enable, equal to the direction register.

Function
REQ-016 SHALL pass gpio_in through a 2-flop synchronizer; the result is sync_in.
REQ-017 SHALL derive filt_in: the debounced sync_in when debounce is compiled in, otherwise sync_in.
REQ-018 SHALL register filt_in into prev_in each cycle and detect an edge per bit from prev_in vs filt_in according to EDGE_MODE.
REQ-019 SHALL set capture bit n in the cycle after an edge on bit n is detected; the bit stays set until cleared.
REQ-020 SHALL clear capture bits on a write to address 3 where the writedata bit is 1 (W1C); writedata bits of 0 leave the bit unchanged.
REQ-021 SHALL give set priority: an edge and a W1C on the same bit in the same cycle leaves the bit at 1.
REQ-022 SHALL, on a write to address 0, 1 or 2, load data, direction or mask from writedata[DW-1:0], effective the next cycle.
REQ-023 SHALL return readdata one cycle after a qualified read; readdata holds its value when no read occurs.
REQ-024 SHALL return on a read of address 0, per bit, gpio_out when direction=1, else filt_in.
REQ-025 SHALL return on reads of addresses 1, 2 and 3 the direction, mask and capture registers respectively.
REQ-026 SHALL drive irq as a register of OR-reduce(capture AND mask), one cycle after the capture/mask update.
REQ-027 SHALL ignore a write with chipselect=0; read and write asserted together SHALL perform both operations.

Reset
REQ-028 SHALL, while reset=1 at a clk edge, set data, direction, mask, capture, readdata and irq to 0.
REQ-029 SHALL, on reset, load the synchronizer, prev_in and the debounced state with 0 and clear the debounce counters.
REQ-030 SHALL discard any pending edge or debounce count when reset asserts mid-operation; no capture bit is set on the first cycle after reset deassertion.

Configuration
REQ-031 SHALL compile a per-bit debounce filter when macro PARALLEL_PORT_DEBOUNCE_EN is defined.
REQ-032 SHALL, with the filter compiled in, update debounced bit n only after sync_in[n] differs from it for DEBOUNCE_CYCLES consecutive cycles, and SHALL zero the counter whenever sync_in[n] equals the debounced value.
REQ-033 SHALL, without the macro, contain no debounce counters; filt_in equals sync_in and DEBOUNCE_CYCLES is unused.

Verification
REQ-034 SHALL verify write/read: write 0xA5 to address 0 and 0xFF to address 1 -> gpio_out=0xA5, gpio_oe=0xFF, a read of address 0 returns 0xA5 one cycle after the read.
REQ-035 SHALL verify rising capture: EDGE_MODE=0, mask=0x1, gpio_in[0] 0->1 -> capture=0x1, irq=1; W1C 0x1 -> capture=0, irq=0 next cycle.
REQ-036 SHALL verify the collision: W1C of bit 2 in the same cycle a new edge on bit 2 is detected -> capture bit 2 stays 1.
REQ-037 SHALL verify debounce with the macro defined and DEBOUNCE_CYCLES=16: a 10-cycle glitch sets no capture bit; a 20-cycle high sets capture exactly once.
REQ-038 SHALL verify reset mid-operation: assert reset with capture=0xF and mask=0xF -> all registers 0 and irq=0 the next cycle, with no spurious capture after release.
REQ-039 SHALL verify EDGE_MODE=2: a 0->1->0 pulse on bit 3 (held 20 cycles each) sets capture bit 3, which remains set with a single irq.
